// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and a per-register
// pending-write scoreboard for issue/writeback tracking.
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wbEn,
  input  logic [4:0]      wd,
  input  logic [XLEN-1:0] wbData,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1Busy,
  output logic            rs2Busy,
  input  logic            allocEn,
  input  logic [4:0]      allocRd,
  output logic            allocReady,
  input  logic            flush
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [PEND_W-1:0] cnt_q  [NREG];
  logic [PEND_W-1:0] cnt_d  [NREG];

  logic wb_live;
  logic inc;
  logic dec;

  assign wb_live    = wbEn && (wd != 5'd0);
  assign allocReady = (allocRd == 5'd0) || (cnt_q[allocRd] != CNT_MAX);
  assign inc        = allocEn && allocReady && (allocRd != 5'd0);
  assign dec        = wb_live && (cnt_q[wd] != '0);

  assign rd1 = (ra1 == 5'd0) ? '0 :
               (wbEn && wd == ra1) ? wbData : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 :
               (wbEn && wd == ra2) ? wbData : regs_q[ra2];

  // The last pending write retiring this cycle is covered by the bypass.
  assign rs1Busy = (ra1 != 5'd0) && (cnt_q[ra1] != '0) &&
                   !(wbEn && wd == ra1 && cnt_q[ra1] == CNT_ONE);
  assign rs2Busy = (ra2 != 5'd0) && (cnt_q[ra2] != '0) &&
                   !(wbEn && wd == ra2 && cnt_q[ra2] == CNT_ONE);

  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[wd] = wbData;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
    end else if (!(inc && dec && allocRd == wd)) begin
      if (inc) cnt_d[allocRd] = cnt_q[allocRd] + CNT_ONE;
      if (dec) cnt_d[wd] = cnt_q[wd] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, scoreboard,
// saturation, flush priority and underflow.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbEn;
  logic [4:0]  wd;
  logic [63:0] wbData;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic        rs1Busy;
  logic        rs2Busy;
  logic        allocEn;
  logic [4:0]  allocRd;
  logic        allocReady;
  logic        flush;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.XLEN(64), .NREG(32), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbEn(wbEn), .wd(wd), .wbData(wbData),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
    .allocEn(allocEn), .allocRd(allocRd),
    .allocReady(allocReady), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbEn = 0; wd = 0; wbData = '0;
    allocEn = 0; allocRd = 0; flush = 0;
  endtask

  initial begin
    rst_n = 0; ra1 = 0; ra2 = 0;
    idle();
    #1;
    chk("rst_rd1", rd1, 64'h0);
    chk("rst_ready", {63'b0, allocReady}, 64'h1);
    #11 rst_n = 1;
    tick();

    // write x5 and allocate it, then async reset mid-cycle
    wbEn = 1; wd = 5; wbData = 64'hDEAD;
    allocEn = 1; allocRd = 5;
    tick();
    idle(); ra1 = 5; allocRd = 5; #1;
    chk("x5_written", rd1, 64'hDEAD);
    chk("x5_busy", {63'b0, rs1Busy}, 64'h1);
    #2 rst_n = 0; #1;
    chk("mid_rst_rd1", rd1, 64'h0);
    chk("mid_rst_busy", {63'b0, rs1Busy}, 64'h0);
    chk("mid_rst_ready", {63'b0, allocReady}, 64'h1);
    #1 rst_n = 1; #1;
    chk("post_rst_rd1", rd1, 64'h0);
    tick();

    // write with same-cycle bypass, then from array; x0 stays zero
    wbEn = 1; wd = 3; wbData = 64'h1234; ra1 = 3; #1;
    chk("bypass_rd1", rd1, 64'h1234);
    tick();
    idle(); #1;
    chk("array_rd1", rd1, 64'h1234);
    wbEn = 1; wd = 0; wbData = 64'hFF; ra2 = 0; #1;
    chk("x0_bypass", rd2, 64'h0);
    tick();
    idle(); #1;
    chk("x0_array", rd2, 64'h0);

    // scoreboard round trip on x7
    allocEn = 1; allocRd = 7; #1;
    chk("x7_ready", {63'b0, allocReady}, 64'h1);
    tick();
    idle(); ra1 = 7; ra2 = 7; #1;
    chk("x7_busy1", {63'b0, rs1Busy}, 64'h1);
    chk("x7_busy2", {63'b0, rs2Busy}, 64'h1);
    wbEn = 1; wd = 7; wbData = 64'h77; #1;
    chk("x7_retire_busy", {63'b0, rs1Busy}, 64'h0);
    chk("x7_retire_rd1", rd1, 64'h77);
    tick();
    idle(); #1;
    chk("x7_cnt0_busy", {63'b0, rs2Busy}, 64'h0);
    chk("x7_array", rd1, 64'h77);

    // saturation on x9
    allocEn = 1; allocRd = 9;
    tick(); tick(); tick();
    #1;
    chk("x9_sat", {63'b0, allocReady}, 64'h0);
    tick();
    allocEn = 0; wbEn = 1; wd = 9; wbData = 64'h9;
    tick();
    idle(); allocRd = 9; ra1 = 9; #1;
    chk("x9_ready_after_wb", {63'b0, allocReady}, 64'h1);
    chk("x9_busy_cnt2", {63'b0, rs1Busy}, 64'h1);
    allocEn = 1; wbEn = 1; wd = 9; wbData = 64'h99;
    tick();
    idle(); ra1 = 9; wbEn = 1; wd = 9; #1;
    chk("x9_still_busy", {63'b0, rs1Busy}, 64'h1);
    tick();
    #1;
    chk("x9_last_retire", {63'b0, rs1Busy}, 64'h0);
    tick();
    idle(); ra1 = 9; #1;
    chk("x9_idle", {63'b0, rs1Busy}, 64'h0);

    // flush priority: cnt4=2, cnt6=1
    allocEn = 1; allocRd = 4; tick(); tick();
    allocRd = 6; tick();
    idle(); ra1 = 4; ra2 = 6; #1;
    chk("x4_busy", {63'b0, rs1Busy}, 64'h1);
    chk("x6_busy", {63'b0, rs2Busy}, 64'h1);
    flush = 1; allocEn = 1; allocRd = 4;
    wbEn = 1; wd = 6; wbData = 64'h55;
    tick();
    idle(); allocRd = 4; #1;
    chk("flush_x4", {63'b0, rs1Busy}, 64'h0);
    chk("flush_x6", {63'b0, rs2Busy}, 64'h0);
    chk("flush_rd6", rd2, 64'h55);
    chk("flush_ready4", {63'b0, allocReady}, 64'h1);

    // underflow on x12
    wbEn = 1; wd = 12; wbData = 64'hABC; ra1 = 12; #1;
    chk("uf_bypass", rd1, 64'hABC);
    chk("uf_busy_wb", {63'b0, rs1Busy}, 64'h0);
    tick();
    idle(); allocRd = 12; #1;
    chk("uf_rd1", rd1, 64'hABC);
    chk("uf_busy", {63'b0, rs1Busy}, 64'h0);
    chk("uf_ready", {63'b0, allocReady}, 64'h1);
    allocEn = 1;
    tick();
    idle(); #1;
    chk("uf_alloc_busy", {63'b0, rs1Busy}, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
